// File: rtl/io_pkg.sv
// io_pkg: bus addresses, status bit positions and poll states shared by the
// I/O poll controller and its bench.
package io_pkg;
    localparam logic [31:0] MY_NAMESPACE = 32'hF000_0200;
    localparam logic [31:0] IACK_ADDR    = 32'hF000_0204;
    localparam logic [31:0] DEV0_ADDR    = 32'hF000_0110;
    localparam logic [31:0] DEV1_ADDR    = 32'hF000_0114;
    localparam logic [31:0] DEV2_ADDR    = 32'hF000_0124;
    localparam int          READY_BIT    = 0;
    localparam int          OVR_BIT      = 2;

    typedef enum logic [1:0] {GAP, RD0, RD1, RD2} poll_state_t;

    function automatic logic [31:0] dev_addr(input logic [1:0] idx);
        return (idx == 2'd0) ? DEV0_ADDR : (idx == 2'd1) ? DEV1_ADDR : DEV2_ADDR;
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: registers the interrupt request and the index of the
// lowest-numbered pending unmasked device (3 when none).
module irq_prio_enc (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_req,
    output logic       o_irq,
    output logic [1:0] o_irq_id
);
    logic       r_irq;
    logic [1:0] r_irq_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq    <= 1'b0;
            r_irq_id <= 2'd3;
        end else begin
            r_irq    <= |i_req;
            r_irq_id <= i_req[0] ? 2'd0 : i_req[1] ? 2'd1 : i_req[2] ? 2'd2 : 2'd3;
        end
    end

    assign o_irq    = r_irq;
    assign o_irq_id = r_irq_id;
endmodule

// File: rtl/io_poll_ctrl.sv
// io_poll_ctrl: reads each device control register while the CPU is off the
// bus, latches pending/overrun flags and raises a masked priority interrupt.
module io_poll_ctrl
    import io_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int POLL_GAP = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpuReq,
    input  logic [DBITS-1:0] cpuAddr,
    input  logic             cpuWrtEn,
    output logic [DBITS-1:0] address,
    output logic             wrtEn,
    inout  wire  [DBITS-1:0] dbus,
    output logic             irq,
    output logic [1:0]       irqId
);
    localparam int            CW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(POLL_GAP - 1);

    poll_state_t      r_state, w_state_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [2:0]       r_pend, r_ovf, r_mask;
    logic [1:0]       w_dev;
    logic             w_polling, w_sample, w_stat_rd, w_stat_wr, w_iack_wr;
    logic [2:0]       w_set_pend, w_set_ovf, w_clr_pend, w_clr_ovf;
    logic [DBITS-1:0] w_status;
    logic             w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= GAP;
            r_cnt   <= GAP_LOAD;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // A CPU access during a read cycle stalls the scan on the same device.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == GAP) begin
            w_state_nx = (r_cnt == '0) ? RD0 : GAP;
            w_cnt_nx   = r_cnt - CW'(1);
        end else if (!cpuReq) begin
            w_state_nx = (r_state == RD0) ? RD1 : (r_state == RD1) ? RD2 : GAP;
            w_cnt_nx   = GAP_LOAD;
        end
    end

    assign w_polling = (r_state != GAP);
    assign w_dev     = (r_state == RD0) ? 2'd0 : (r_state == RD1) ? 2'd1 : 2'd2;
    assign w_sample  = w_polling & ~cpuReq;

    assign address = (cpuReq | ~w_polling) ? cpuAddr : DBITS'(dev_addr(w_dev));
    assign wrtEn   = cpuReq & cpuWrtEn;

    assign w_stat_rd = cpuReq & ~cpuWrtEn & (address == MY_NAMESPACE);
    assign w_stat_wr = cpuReq &  cpuWrtEn & (address == MY_NAMESPACE);
    assign w_iack_wr = cpuReq &  cpuWrtEn & (address == IACK_ADDR);

    assign w_status = {{(DBITS-11){1'b0}}, r_mask, 1'b0, r_ovf, 1'b0, r_pend};
    assign dbus     = w_stat_rd ? w_status : 'z;

    assign w_set_pend = {2'b00, w_sample & dbus[READY_BIT]} << w_dev;
    assign w_set_ovf  = {2'b00, w_sample & dbus[OVR_BIT]} << w_dev;
    assign w_clr_pend = w_iack_wr ? dbus[2:0] : 3'b000;
    assign w_clr_ovf  = w_iack_wr ? dbus[6:4] : 3'b000;
    assign w_unused   = ^{dbus[DBITS-1:11], dbus[7], dbus[3]};

    // Clear is applied before set so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 3'b000;
            r_ovf  <= 3'b000;
            r_mask <= 3'b000;
        end else begin
            r_pend <= (r_pend & ~w_clr_pend) | w_set_pend;
            r_ovf  <= (r_ovf & ~w_clr_ovf) | w_set_ovf;
            if (w_stat_wr) r_mask <= dbus[10:8];
        end
    end

    irq_prio_enc u_enc (
        .clk      (clk),
        .reset    (reset),
        .i_req    (r_pend & r_mask),
        .o_irq    (irq),
        .o_irq_id (irqId)
    );
endmodule

// File: doc/io_poll_ctrl.md
# io_poll_ctrl

Bus-mastering poll sequencer and interrupt controller for the memory-mapped I/O devices on the shared tri-state `dbus`. When the CPU is not using the bus, it reads each device controller's control/status register in turn and latches per-device pending and overrun flags. It raises a masked, priority-encoded interrupt to the CPU. It also appears as a bus slave, so the CPU can read status, set the mask and acknowledge.

## Interface
- `DBITS`, 32, bus width.
- `MY_NAMESPACE`, 32'hF000_0200, status/mask register address.
- `IACK_ADDR`, 32'hF000_0204, acknowledge register address; write-only.
- `DEV0_ADDR`, 32'hF000_0110, key controller control register.
- `DEV1_ADDR`, 32'hF000_0114, switch controller control register.
- `DEV2_ADDR`, 32'hF000_0124, timer controller control register.
- `POLL_GAP`, 16, idle cycles between scan rounds; minimum 1.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `cpuReq`  in  1  CPU performs a bus access this cycle.
- `cpuAddr`  in  DBITS  CPU address.
- `cpuWrtEn`  in  1  CPU write strobe.
- `address`  out  DBITS  shared bus address.
- `wrtEn`  out  1  shared bus write strobe.
- `dbus`  inout  DBITS  shared data bus.
- `irq`  out  1  interrupt request, registered.
- `irqId`  out  2  index of the lowest-numbered pending unmasked device; 3 = none.

## Operation
**Bus mux**
- With `cpuReq`=1: `address`=`cpuAddr` and `wrtEn`=`cpuWrtEn`.
- Otherwise: `address`=current poll address in states RD0–RD2, else `cpuAddr`; `wrtEn`=0.
- The engine never writes and only reads DEVn control registers. Those reads are non-destructive; data registers, whose read clears ready, are never touched.

**FSM**
- GAP: counter counts POLL_GAP-1 down to 0, then goes to RD0.
- RD0 → RD1 → RD2 → GAP, with the counter reloaded on entering GAP.
- In any RDn cycle with `cpuReq`=1, the state holds, nothing is sampled, and the same device is retried next cycle.
- In RDn with `cpuReq`=0, `dbus` is sampled at posedge:
  - bit0 (ready)=1 sets `pend[n]`.
  - bit2 (overrun)=1 sets `ovf[n]`.

**Slave registers** (decoded from `address`, CPU cycles only)
- Read `MY_NAMESPACE`: drives `dbus` = {21'd0, mask[2:0] at [10:8], 1'b0, ovf[2:0] at [6:4], 1'b0, pend[2:0] at [2:0]}. All other cycles: `dbus`=Z.
- Write `MY_NAMESPACE`: `mask` <= `dbus[10:8]`.
- Write `IACK_ADDR`: write-1-to-clear. `pend[i]` clears where `dbus[i]`=1; `ovf[i]` clears where `dbus[4+i]`=1.
- Set and clear of the same bit in one cycle: set wins.

**Outputs**
- `irq` <= |(pend & mask).
- `irqId` <= lowest i with pend[i]&mask[i], else 3.

## Timing
- Reset values:
  - FSM=GAP, counter=POLL_GAP-1.
  - `pend`=0, `ovf`=0, `mask`=0.
  - `irq`=0, `irqId`=3.
  - `wrtEn`=0; `dbus`=Z; `address` follows `cpuAddr`.
- Reset mid-scan aborts the round and applies reset values the next cycle. No partial sample is kept.
- Uncontested round: 3 cycles. A `pend` bit is visible in status the cycle after its sample; `irq` follows 1 cycle later.
- Worst-case latency from device ready to `irq`, uncontested: POLL_GAP+3+1 cycles. CPU-held cycles add 1 each.
- `mask` write takes effect on `irq` 2 cycles after the write edge.
- Status read is combinational in the same cycle, as for every other device.

## Structure
- Shared package `io_pkg`:
  - device address constants (DEVn_ADDR, MY_NAMESPACE, IACK_ADDR).
  - status bit positions (READY_BIT=0, OVR_BIT=2).
  - FSM state enum {GAP, RD0, RD1, RD2}.
- One natural sub-module: `irq_prio_enc` (3-bit pend&mask → `irq`, `irqId`). The rest stays flat.

## Test plan
- Reset, then idle with all DEVn reading 0: `irq`=0 and `irqId`=3 indefinitely. `address` cycles DEV0/1/2 every POLL_GAP+3 cycles; `wrtEn` is never 1.
- DEV1 returns 32'h1 and `mask`=3'b010: `pend`=3'b010, `irq`=1, `irqId`=1 within 20 cycles. Write 32'h2 to IACK_ADDR → `irq`=0 two cycles later.
- DEV0 and DEV2 both ready, `mask`=3'b111: `irqId`=0. Ack bit0 → `irqId`=2. Ack bit2 → `irqId`=3.
- `cpuReq` held high for 5 cycles during RD1: `address`=`cpuAddr` throughout, DEV1 is not sampled, and RD1 resumes at the same address on release.
- DEV2 returns 32'h5: status read gives 32'h0000_0044 with `mask`=0, and `irq` stays 0. Same-cycle ack of bit2 while DEV2 still reads ready leaves `pend[2]`=1.
- `reset` asserted in RD1 with `pend`=3'b001: next cycle `pend`=0, `irq`=0, FSM=GAP.
